// File: rtl/decoder4_pkg.sv
`default_nettype none
//============================================================================
// Module  : decoder4_pkg
// Desc    : Shared types and constants for the decoder4 controller.
// Revision: 1.0 - initial release
//============================================================================
package decoder4_pkg;

    localparam int   c_DEF_DATA_W  = 8;
    localparam int   c_DEF_PAT_W   = 4;
    localparam logic c_FRAME_START = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PROG   = 3'd1,
        ST_SETTLE = 3'd2,
        ST_STREAM = 3'd3,
        ST_DRAIN  = 3'd4,
        ST_RESULT = 3'd5
    } state_t;

    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/decoder4_if.sv
`default_nettype none
//============================================================================
// Module  : decoder4_if
// Desc    : Config / data / result handshake bundle for decoder4_ctrl.
// Revision: 1.0 - initial release
//============================================================================
interface decoder4_if
    import decoder4_pkg::*;
#(
    parameter int DATA_W = c_DEF_DATA_W,
    parameter int PAT_W  = c_DEF_PAT_W
);
    logic [PAT_W-1:0]              cfg_pat;
    logic                          cfg_valid;
    logic                          cfg_ready;
    logic [DATA_W-1:0]             in_data;
    logic                          in_valid;
    logic                          in_ready;
    logic [DATA_W-1:0]             res_mask;
    logic [$clog2(DATA_W+1)-1:0]   res_cnt;
    logic                          res_valid;
    logic                          res_ready;

    modport master (
        output cfg_pat, cfg_valid, in_data, in_valid, res_ready,
        input  cfg_ready, in_ready, res_mask, res_cnt, res_valid
    );

    modport slave (
        input  cfg_pat, cfg_valid, in_data, in_valid, res_ready,
        output cfg_ready, in_ready, res_mask, res_cnt, res_valid
    );
endinterface
`default_nettype wire

// File: rtl/decoder4_ser.sv
`default_nettype none
//============================================================================
// Module  : decoder4_ser
// Desc    : Parallel-load MSB-first serializer with bit counter and done flag.
// Revision: 1.0 - initial release
//============================================================================
module decoder4_ser
    import decoder4_pkg::*;
#(
    parameter int WIDTH = c_DEF_DATA_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             shift,
    output logic             ser_bit,
    output logic             done
);
    localparam int c_CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0]   r_sh;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_bit;

    // Output bit is a flop: it returns to 0 whenever no bit is being shifted out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sh  <= '0;
            r_cnt <= '0;
            r_bit <= 1'b0;
        end else if (load) begin
            r_sh  <= load_data;
            r_cnt <= c_CNT_W'(WIDTH);
            r_bit <= 1'b0;
        end else if (shift && (r_cnt != '0)) begin
            r_bit <= r_sh[WIDTH-1];
            r_sh  <= {r_sh[WIDTH-2:0], 1'b0};
            r_cnt <= r_cnt - c_CNT_W'(1);
        end else begin
            r_bit <= 1'b0;
        end
    end

    assign ser_bit = r_bit;
    assign done    = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/decoder4_ctrl.sv
`default_nettype none
//============================================================================
// Module  : decoder4_ctrl
// Desc    : Programs an external decoder4 and streams words through it,
//           collecting per-bit match flags.
// Revision: 1.0 - initial release
//============================================================================
module decoder4_ctrl
    import decoder4_pkg::*;
#(
    parameter int DATA_W = c_DEF_DATA_W,
    parameter int PAT_W  = c_DEF_PAT_W
) (
    input  logic        clk,
    input  logic        rst_n,
    decoder4_if.slave   bus,
    output logic        dec_prgm,
    output logic        dec_sig,
    input  logic        dec_out,
    output logic        programmed,
    output logic [15:0] match_total
);
    localparam int c_CNT_W = $clog2(DATA_W + 1);
    localparam int c_IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    state_t             r_state;
    logic               r_cfg_rdy;
    logic               r_res_vld;
    logic [DATA_W-1:0]  r_mask;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_prog;
    logic [15:0]        r_total;
    logic               r_smp_d1;
    logic               r_smp_en;
    logic [c_IDX_W-1:0] r_idx;

    logic               w_cfg_hs;
    logic               w_in_rdy;
    logic               w_in_hs;
    logic               w_frm_done;
    logic               w_dat_done;
    logic [c_CNT_W-1:0] w_cnt_nxt;

    // Config wins over data when both are offered in IDLE.
    assign w_cfg_hs  = r_cfg_rdy & bus.cfg_valid;
    assign w_in_rdy  = r_cfg_rdy & r_prog & ~bus.cfg_valid;
    assign w_in_hs   = w_in_rdy & bus.in_valid;
    assign w_cnt_nxt = r_cnt + c_CNT_W'(dec_out);

    decoder4_ser #(.WIDTH(PAT_W + 1)) u_frame_ser (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (w_cfg_hs),
        .load_data ({c_FRAME_START, bus.cfg_pat}),
        .shift     (r_state == ST_PROG),
        .ser_bit   (dec_prgm),
        .done      (w_frm_done)
    );

    decoder4_ser #(.WIDTH(DATA_W)) u_data_ser (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (w_in_hs),
        .load_data (bus.in_data),
        .shift     (r_state == ST_STREAM),
        .ser_bit   (dec_sig),
        .done      (w_dat_done)
    );

    // A bit leaves the serializer one cycle after being shifted and the decoder
    // answers one cycle later, so sampling trails the shift by two cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_cfg_rdy <= 1'b1;
            r_res_vld <= 1'b0;
            r_mask    <= '0;
            r_cnt     <= '0;
            r_prog    <= 1'b0;
            r_total   <= '0;
            r_smp_d1  <= 1'b0;
            r_smp_en  <= 1'b0;
            r_idx     <= '0;
        end else begin
            r_smp_d1 <= (r_state == ST_STREAM) && !w_dat_done;
            r_smp_en <= r_smp_d1;
            if (r_smp_en) begin
                r_mask[r_idx] <= dec_out;
                r_cnt         <= w_cnt_nxt;
                r_idx         <= r_idx - c_IDX_W'(1);
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_cfg_hs) begin
                        r_state   <= ST_PROG;
                        r_cfg_rdy <= 1'b0;
                    end else if (w_in_hs) begin
                        r_state   <= ST_STREAM;
                        r_cfg_rdy <= 1'b0;
                        r_mask    <= '0;
                        r_cnt     <= '0;
                        r_idx     <= c_IDX_W'(DATA_W - 1);
                    end
                end
                ST_PROG: begin
                    if (w_frm_done) r_state <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    r_prog    <= 1'b1;
                    r_state   <= ST_IDLE;
                    r_cfg_rdy <= 1'b1;
                end
                ST_STREAM: begin
                    if (w_dat_done) r_state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    r_state   <= ST_RESULT;
                    r_res_vld <= 1'b1;
                    r_total   <= sat_add16(r_total, 16'(w_cnt_nxt));
                end
                ST_RESULT: begin
                    if (bus.res_ready) begin
                        r_state   <= ST_IDLE;
                        r_res_vld <= 1'b0;
                        r_cfg_rdy <= 1'b1;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_cfg_rdy <= 1'b1;
                end
            endcase
        end
    end

    assign bus.cfg_ready = r_cfg_rdy;
    assign bus.in_ready  = w_in_rdy;
    assign bus.res_mask  = r_mask;
    assign bus.res_cnt   = r_cnt;
    assign bus.res_valid = r_res_vld;
    assign programmed    = r_prog;
    assign match_total   = r_total;

endmodule
`default_nettype wire

// File: doc/decoder4_ctrl.md
DECODER4_CTRL -- requirements
Module: decoder4_ctrl

Interface
REQ-001 Parameter DATA_W, default 8, meaning data word width, serialized MSB first onto decoder sig.
REQ-002 Parameter PAT_W, default 4, meaning decoder pattern width.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 cfg_pat  input  PAT_W  pattern to program into decoder.
REQ-006 cfg_valid / cfg_ready  input / output  1  config handshake; transfer when both high on a clk edge.
REQ-007 in_data  input  DATA_W  word to stream through decoder.
REQ-008 in_valid / in_ready  input / output  1  data handshake.
REQ-009 res_mask  output  DATA_W  per-bit match flags for last word.
REQ-010 res_cnt  output  $clog2(DATA_W+1)  number of set bits in res_mask.
REQ-011 res_valid / res_ready  output / input  1  result handshake.
REQ-012 dec_prgm, dec_sig  output  1  drive decoder4 prgm and sig.
REQ-013 dec_out  input  1  decoder4 out.
REQ-014 programmed  output  1  high once a pattern has been loaded since reset.
REQ-015 match_total  output  16  saturating count of all matches since reset.

Function
REQ-016 Decoder protocol: program frame on dec_prgm = start bit 1, then PAT_W pattern bits MSB first; dec_prgm idles 0; frame clears decoder sig history to 0.
REQ-017 dec_out is registered in decoder: reflects window ending with sig bit driven in cycle t during cycle t+1.
REQ-018 FSM states: IDLE, PROG, SETTLE, STREAM, DRAIN, RESULT; reset state IDLE.
REQ-019 IDLE: cfg_ready=1; in_ready=programmed and not cfg_valid (config has priority on simultaneous valid).
REQ-020 IDLE->PROG on cfg handshake; pattern latched; PROG drives PAT_W+1 frame bits, one per cycle; then SETTLE one cycle (dec_prgm=0), set programmed, ->IDLE.
REQ-021 IDLE->STREAM on in handshake; word latched; STREAM drives DATA_W bits on dec_sig, bit DATA_W-1 first, one per cycle.
REQ-022 Sampling: dec_out sampled in cycle after each bit; sample for bit i stored in res_mask[i]; last sample taken in DRAIN (one cycle), then ->RESULT.
REQ-023 dec_sig=0 in all states except STREAM.
REQ-024 RESULT: res_valid=1, res_mask/res_cnt stable; ->IDLE on res_ready; no new cfg or data accepted until then.
REQ-025 Latency: in handshake at edge 0 -> res_valid high after edge DATA_W+2.
REQ-026 res_mask/res_cnt cleared at each STREAM entry; hold previous value otherwise.
REQ-027 match_total adds res_cnt on RESULT entry, saturates at 16'hFFFF.
REQ-028 cfg_ready=0 and in_ready=0 in all states except IDLE.
REQ-029 Reprogramming allowed any time in IDLE; new pattern applies to next word.

Reset
REQ-030 rst_n low asynchronously forces IDLE; dec_prgm=0, dec_sig=0, res_valid=0, res_mask=0, res_cnt=0, programmed=0, match_total=0, cfg_ready=1 (in_ready=0) after release.
REQ-031 Reset mid-PROG or mid-STREAM abandons operation; no result produced; decoder must be reprogrammed.

Structure
REQ-032 Shared package decoder4_pkg holds FSM state enum, DATA_W/PAT_W defaults, frame start-bit constant.
REQ-033 One sub-module natural: decoder4_ser (parallel-load shift register, MSB-first, bit counter, done flag), instantiated for frame and data serialization.

Verification
REQ-034 Reset, in_valid=1 before any config -> in_ready=0, programmed=0, dec_sig=0.
REQ-035 cfg_pat=4'b1011 -> dec_prgm sequence 1,1,0,1,1 then 0; programmed=1 after SETTLE.
REQ-036 Pattern 1011, in_data=8'hBB -> sig 1,0,1,1,1,0,1,1; res_mask=8'b0001_0001, res_cnt=2, res_valid after 10 edges.
REQ-037 cfg_valid and in_valid together in IDLE -> config accepted first, data accepted after SETTLE.
REQ-038 res_ready held 0 for 5 cycles -> result stable, cfg_ready/in_ready stay 0; match_total +2 once.
REQ-039 rst_n pulsed low at STREAM bit 4 -> immediate IDLE, dec_sig=0, no res_valid, programmed=0.
